// File: rtl/if_stage_if.sv
// if_stage_if -- bundle of the fetch stage's control, instruction-memory and
// IF/ID signals.
//   master : used by if_stage (drives imemAddr and the IF/ID/perf outputs)
//   slave  : used by the environment (drives hazard controls, branch
//            redirect and the instruction word)
// Signals:
//   PCWrite       1 = hold PC
//   WriteIFID     1 = hold IF/ID register
//   branchTaken   redirect request from ID
//   branchTarget  redirect address, bits [1:0] ignored
//   imemAddr      instruction memory address (current PC)
//   imemData      instruction word at imemAddr, same cycle
//   instrID       IF/ID instruction
//   pcPlus4ID     IF/ID copy of fetching PC + 4
//   validID       1 = instrID is a real instruction, 0 = bubble
//   stallCycles   perf counter (zero unless IF_PERF_CNT_EN)
//   redirectCount perf counter (zero unless IF_PERF_CNT_EN)
interface if_stage_if;
   logic        PCWrite;
   logic        WriteIFID;
   logic        branchTaken;
   logic [31:0] branchTarget;
   logic [31:0] imemAddr;
   logic [31:0] imemData;
   logic [31:0] instrID;
   logic [31:0] pcPlus4ID;
   logic        validID;
   logic [31:0] stallCycles;
   logic [31:0] redirectCount;

   modport master (
      input  PCWrite, WriteIFID, branchTaken, branchTarget, imemData,
      output imemAddr, instrID, pcPlus4ID, validID, stallCycles, redirectCount
   );

   modport slave (
      output PCWrite, WriteIFID, branchTaken, branchTarget, imemData,
      input  imemAddr, instrID, pcPlus4ID, validID, stallCycles, redirectCount
   );
endinterface

// File: rtl/if_stage.sv
// if_stage -- instruction fetch stage: PC register, next-PC selection and the
// IF/ID pipeline register.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (PC <= RESET_PC, IF/ID and counters cleared)
//   bus  if_stage_if.master: hazard controls, branch redirect, instruction
//        memory address/data, IF/ID outputs and perf counters
// Parameters:
//   RESET_PC  PC loaded on reset (word aligned)
// Configuration:
//   IF_PERF_CNT_EN  when defined, stallCycles counts edges with PCWrite=1 and
//                   redirectCount counts honoured redirects, both saturating;
//                   when undefined, both outputs are constant zero.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic       clk,
   input  logic       rst,
   if_stage_if.master bus
);

   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] pc_next;
   logic        redirect;
   logic        unused_ok;

   // A redirect is only honoured when the PC is free to move.
   always_comb begin
      pc_plus4 = pc + 32'd4;
      redirect = bus.branchTaken & ~bus.PCWrite;
      pc_next  = pc_plus4;
      if (bus.PCWrite)
         pc_next = pc;
      else if (bus.branchTaken)
         pc_next = {bus.branchTarget[31:2], 2'b00};
   end

   assign bus.imemAddr = pc;
   assign unused_ok    = ^bus.branchTarget[1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pc <= RESET_PC_ALIGNED;
      else
         pc <= pc_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.instrID   <= '0;
         bus.pcPlus4ID <= '0;
         bus.validID   <= 1'b0;
      end else if (!bus.WriteIFID) begin
         if (redirect) begin
            bus.instrID   <= '0;
            bus.pcPlus4ID <= '0;
            bus.validID   <= 1'b0;
         end else begin
            bus.instrID   <= bus.imemData;
            bus.pcPlus4ID <= pc_plus4;
            bus.validID   <= 1'b1;
         end
      end
   end

`ifdef IF_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] redirect_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt    <= '0;
         redirect_cnt <= '0;
      end else begin
         if (bus.PCWrite && stall_cnt != '1)
            stall_cnt <= stall_cnt + 32'd1;
         if (redirect && redirect_cnt != '1)
            redirect_cnt <= redirect_cnt + 32'd1;
      end
   end

   assign bus.stallCycles   = stall_cnt;
   assign bus.redirectCount = redirect_cnt;
`else
   assign bus.stallCycles   = '0;
   assign bus.redirectCount = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage -- self-checking bench for if_stage: directed scenarios followed
// by randomized controls, compared against a cycle-level behavioural model.
module tb_if_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   if_stage_if bus();

   if_stage #(.RESET_PC(RST_PC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Instruction memory: every word is tagged by its address.
   function automatic logic [31:0] word_at(input logic [31:0] a);
      return {a[29:0], 2'b11} ^ 32'h1357_9BDF;
   endfunction

   assign bus.imemData = word_at(bus.imemAddr);

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Behavioural model state
   logic [31:0] m_pc, m_instr, m_pp4, m_stall, m_redir;
   logic        m_valid;

   task automatic model_reset();
      m_pc = RST_PC; m_instr = '0; m_pp4 = '0; m_valid = 1'b0;
      m_stall = '0; m_redir = '0;
   endtask

   task automatic model_edge(input logic pcw, input logic wif, input logic bt,
                             input logic [31:0] tgt);
      if (rst) begin
         model_reset();
         return;
      end
      if (!wif) begin
         if (!pcw && bt) begin
            m_instr = '0; m_pp4 = '0; m_valid = 1'b0;
         end else begin
            m_instr = word_at(m_pc); m_pp4 = m_pc + 32'd4; m_valid = 1'b1;
         end
      end
      if (pcw && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (!pcw && bt && m_redir != 32'hFFFF_FFFF) m_redir = m_redir + 1;
      if (!pcw) m_pc = bt ? (tgt & 32'hFFFF_FFFC) : m_pc + 32'd4;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".addr"},  bus.imemAddr, m_pc);
      check({tag, ".instr"}, bus.instrID, m_instr);
      check({tag, ".pp4"},   bus.pcPlus4ID, m_pp4);
      check({tag, ".valid"}, 32'(bus.validID), 32'(m_valid));
`ifdef IF_PERF_CNT_EN
      check({tag, ".stall"}, bus.stallCycles, m_stall);
      check({tag, ".redir"}, bus.redirectCount, m_redir);
`else
      check({tag, ".stall"}, bus.stallCycles, 32'h0);
      check({tag, ".redir"}, bus.redirectCount, 32'h0);
`endif
   endtask

   // Called at a negedge: apply controls, clock one edge, check at next negedge.
   task automatic cycle(input string tag, input logic pcw, input logic wif,
                        input logic bt, input logic [31:0] tgt);
      bus.PCWrite = pcw; bus.WriteIFID = wif; bus.branchTaken = bt; bus.branchTarget = tgt;
      @(posedge clk);
      model_edge(pcw, wif, bt, tgt);
      @(negedge clk);
      check_all(tag);
   endtask

   // Mid-cycle reset pulse spanning one rising edge, with controls left active.
   task automatic async_pulse(input string tag);
      #2 rst = 1'b1;
      model_reset();
      #1 check_all({tag, ".async"});
      @(posedge clk);
      model_edge(bus.PCWrite, bus.WriteIFID, bus.branchTaken, bus.branchTarget);
      @(negedge clk);
      check_all({tag, ".held"});
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.PCWrite = 1'b0; bus.WriteIFID = 1'b0; bus.branchTaken = 1'b0; bus.branchTarget = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all("reset");
      rst = 1'b0;

      // Reset release: sequential fetch 0,4,8
      cycle("seq1", 0, 0, 0, 0);
      check("r030_addr4", bus.imemAddr, 32'h4);
      check("r030_instr", bus.instrID, word_at(32'h0));
      check("r030_valid", 32'(bus.validID), 32'h1);
      cycle("seq2", 0, 0, 0, 0);
      check("r030_addr8", bus.imemAddr, 32'h8);
      cycle("seq3", 0, 0, 0, 0);
      cycle("seq4", 0, 0, 0, 0);
      check("pc_0x10", bus.imemAddr, 32'h10);

      // Full stall for three cycles at PC=0x10
      for (int i = 0; i < 3; i++) cycle("stall", 1, 1, 0, 0);
      check("stall_addr", bus.imemAddr, 32'h10);
      check("stall_instr", bus.instrID, word_at(32'hC));

      // Duplicate fetch: PC held, IF/ID reloads
      cycle("dup", 1, 0, 0, 0);
      check("dup_instr", bus.instrID, word_at(32'h10));

      for (int i = 0; i < 4; i++) cycle("run", 0, 0, 0, 0);
      check("pc_0x20", bus.imemAddr, 32'h20);

      // Redirect with misaligned target
      cycle("br", 0, 0, 1, 32'h103);
      check("br_addr", bus.imemAddr, 32'h100);
      check("br_valid", 32'(bus.validID), 32'h0);
      check("br_instr", bus.instrID, 32'h0);
      cycle("br_tgt", 0, 0, 0, 0);
      check("br_tgt_instr", bus.instrID, word_at(32'h100));
      check("br_tgt_valid", 32'(bus.validID), 32'h1);

      // Redirect while stalled: ignored entirely
      cycle("br_ign", 1, 1, 1, 32'h200);
      check("br_ign_addr", bus.imemAddr, 32'h104);

      // PC wrap-around
      cycle("wrap_br", 0, 0, 1, 32'hFFFF_FFFC);
      cycle("wrap1", 0, 0, 0, 0);
      check("wrap_addr", bus.imemAddr, 32'h0);
      check("wrap_pp4", bus.pcPlus4ID, 32'h0);

      // Asynchronous reset during a stall at PC=0x40
      cycle("to40", 0, 0, 1, 32'h40);
      cycle("st40", 1, 1, 0, 0);
      async_pulse("r035");
      bus.PCWrite = 1'b0; bus.WriteIFID = 1'b0;
      cycle("post_rst", 0, 0, 0, 0);
      check("post_rst_instr", bus.instrID, word_at(RST_PC));

      // Randomized controls
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(31) == 0) begin
            bus.PCWrite = 1'($urandom); bus.WriteIFID = 1'($urandom);
            bus.branchTaken = 1'($urandom);
            async_pulse("rnd_rst");
         end else begin
            cycle("rnd", $urandom_range(3) == 0, $urandom_range(3) == 0,
                  $urandom_range(3) == 0, $urandom);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
